// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch controller. It owns the PC, addresses the
//            asynchronous instruction ROM and holds one fetched word in a
//            buffer that decode drains over a valid/ready handshake. It also
//            handles redirect, halt/resume and traps on illegal fetch PCs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [1:0]  state,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FAULT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_fault;
    logic [31:0] r_fault_pc;
    logic [15:0] r_fetch_count;

    logic w_buf_free;
    logic w_xfer;
    logic w_pc_legal;

    // The buffer can take a new word when it is empty or is being drained now.
    assign w_xfer     = r_if_valid && id_ready;
    assign w_buf_free = !r_if_valid || id_ready;
    assign w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc < MEM_BYTES);

    // Control FSM, PC, fetch buffer and fault capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'd0;
            r_if_pc       <= 32'd0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
            r_fetch_count <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A held word keeps draining while the fetcher is idle.
                    if (w_xfer) begin
                        r_if_valid <= 1'b0;
                    end
                    if (redirect_valid) begin
                        r_pc       <= redirect_target;
                        r_if_valid <= 1'b0;
                    end
                    // start takes precedence over a coincident halt_req.
                    if (start) begin
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (redirect_valid) begin
                        // Target legality is checked on the next fetch attempt.
                        r_pc       <= redirect_target;
                        r_if_valid <= 1'b0;
                    end else if (halt_req) begin
                        r_state <= c_IDLE;
                        if (w_xfer) begin
                            r_if_valid <= 1'b0;
                        end
                    end else if (w_buf_free) begin
                        if (w_pc_legal) begin
                            r_if_instr    <= imem_instr;
                            r_if_pc       <= r_pc;
                            r_if_valid    <= 1'b1;
                            r_pc          <= r_pc + 32'd4;
                            r_fetch_count <= r_fetch_count + 16'd1;
                        end else begin
                            r_state    <= c_FAULT;
                            r_fault    <= 1'b1;
                            r_fault_pc <= r_pc;
                            r_if_valid <= 1'b0;
                        end
                    end
                end
                c_FAULT: begin
                    // Terminal until reset; all requests are ignored.
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;
    assign state       = r_state;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
